// File: rtl/mask_gen.sv
// Two-stage pipelined mask generator: LO/HI/RANGE/WRAP masks from a pair of
// clamped bit indices, with population count and zero/all-ones flags.
module mask_gen #(
  parameter  int W  = 32,
  localparam int IW = $clog2(W) + 1,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [1:0]    in_mode,
  input  logic [IW-1:0] in_a,
  input  logic [IW-1:0] in_b,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [W-1:0]  out_mask,
  output logic [CW-1:0] out_cnt,
  output logic          out_zero,
  output logic          out_ones
);

  localparam logic [IW-1:0] W_IX    = IW'(W);
  localparam logic [1:0]    M_LO    = 2'd0;
  localparam logic [1:0]    M_HI    = 2'd1;
  localparam logic [1:0]    M_RANGE = 2'd2;

  function automatic logic [IW-1:0] sat_idx(input logic [IW-1:0] x);
    return (x > W_IX) ? W_IX : x;
  endfunction

  // Thermometer code: bits [x-1:0] set.
  function automatic logic [W-1:0] thermo(input logic [IW-1:0] x);
    logic [W-1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) t[i] = (IW'(i) < x);
    return t;
  endfunction

  function automatic logic [CW-1:0] count_of(input logic [1:0] mode,
                                             input logic [IW-1:0] a,
                                             input logic [IW-1:0] b);
    logic [IW:0] r;
    r = '0;
    case (mode)
      M_LO:    r = {1'b0, a};
      M_HI:    r = {1'b0, W_IX} - {1'b0, a};
      M_RANGE: r = (a < b) ? ({1'b0, b} - {1'b0, a}) : '0;
      default: r = (a <= b) ? ({1'b0, b} - {1'b0, a})
                            : ({1'b0, W_IX} - {1'b0, a} + {1'b0, b});
    endcase
    return CW'(r);
  endfunction

  function automatic logic [W-1:0] mask_of(input logic [1:0] mode,
                                           input logic [IW-1:0] a,
                                           input logic [IW-1:0] b,
                                           input logic [W-1:0] ta,
                                           input logic [W-1:0] tb);
    logic [W-1:0] m;
    m = '0;
    case (mode)
      M_LO:    m = ta;
      M_HI:    m = ~ta;
      M_RANGE: m = (a < b) ? (tb & ~ta) : '0;
      default: m = (a <= b) ? (tb & ~ta) : (~ta | tb);
    endcase
    return m;
  endfunction

  logic          vld_p1, vld_p2, ld_p1, ld_p2;
  logic [IW-1:0] a_p0, b_p0, a_p1, b_p1;
  logic [1:0]    mode_p1;
  logic [W-1:0]  ta_p1, tb_p1, mask_p1, mask_p2;
  logic [CW-1:0] cnt_p1, cnt_p2;
  logic          zero_p2, ones_p2;

  // No skid buffer: ready ripples combinationally back from out_rdy.
  assign ld_p2  = ~vld_p2 | out_rdy;
  assign ld_p1  = ~vld_p1 | ld_p2;
  assign in_rdy = ld_p1;

  // ---- stage 0 -> 1: clamp indices, build thermometers and count ----
  assign a_p0 = sat_idx(in_a);
  assign b_p0 = sat_idx(in_b);

  always_ff @(posedge clk) begin
    if (rst)        vld_p1 <= 1'b0;
    else if (ld_p1) vld_p1 <= in_vld;
  end

  always_ff @(posedge clk) begin
    if (ld_p1 && in_vld) begin
      a_p1    <= a_p0;
      b_p1    <= b_p0;
      mode_p1 <= in_mode;
      ta_p1   <= thermo(a_p0);
      tb_p1   <= thermo(b_p0);
      cnt_p1  <= count_of(in_mode, a_p0, b_p0);
    end
  end

  // ---- stage 1 -> 2: combine thermometers into the mask and flags ----
  assign mask_p1 = mask_of(mode_p1, a_p1, b_p1, ta_p1, tb_p1);

  always_ff @(posedge clk) begin
    if (rst)        vld_p2 <= 1'b0;
    else if (ld_p2) vld_p2 <= vld_p1;
  end

  // Output data has defined reset values, so this stage's data is reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_p2 <= '0;
      cnt_p2  <= '0;
      zero_p2 <= 1'b1;
      ones_p2 <= 1'b0;
    end else if (ld_p2 && vld_p1) begin
      mask_p2 <= mask_p1;
      cnt_p2  <= cnt_p1;
      zero_p2 <= ~|mask_p1;
      ones_p2 <= &mask_p1;
    end
  end

  assign out_vld  = vld_p2;
  assign out_mask = mask_p2;
  assign out_cnt  = cnt_p2;
  assign out_zero = zero_p2;
  assign out_ones = ones_p2;

endmodule

// File: tb/tb_mask_gen.sv
// Bench for mask_gen: three widths (32, 12, 33) share one request stream and
// are scored against a set-membership reference model with per-width queues.
module tb_mask_gen;

  localparam int WV[3]  = '{32, 12, 33};
  localparam int IWV[3] = '{6, 5, 7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_vld = 1'b1;
  logic [1:0]  in_mode = 2'd0;
  logic [6:0]  ia = 7'd0, ib = 7'd0;
  logic [2:0]  ordy = 3'b111;
  wire  [2:0]  irdy, ovld, ozero, oones;
  wire  [31:0] m32;
  wire  [11:0] m12;
  wire  [32:0] m33;
  wire  [5:0]  c32, c33;
  wire  [3:0]  c12;
  logic [63:0] omask[3], ocnt[3];

  mask_gen #(.W(32)) u_w32 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(irdy[0]), .in_mode(in_mode),
    .in_a(ia[5:0]), .in_b(ib[5:0]), .out_vld(ovld[0]), .out_rdy(ordy[0]),
    .out_mask(m32), .out_cnt(c32), .out_zero(ozero[0]), .out_ones(oones[0]));

  mask_gen #(.W(12)) u_w12 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(irdy[1]), .in_mode(in_mode),
    .in_a(ia[4:0]), .in_b(ib[4:0]), .out_vld(ovld[1]), .out_rdy(ordy[1]),
    .out_mask(m12), .out_cnt(c12), .out_zero(ozero[1]), .out_ones(oones[1]));

  mask_gen #(.W(33)) u_w33 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(irdy[2]), .in_mode(in_mode),
    .in_a(ia), .in_b(ib), .out_vld(ovld[2]), .out_rdy(ordy[2]),
    .out_mask(m33), .out_cnt(c33), .out_zero(ozero[2]), .out_ones(oones[2]));

  assign omask[0] = 64'(m32);
  assign omask[1] = 64'(m12);
  assign omask[2] = 64'(m33);
  assign ocnt[0]  = 64'(c32);
  assign ocnt[1]  = 64'(c12);
  assign ocnt[2]  = 64'(c33);

  typedef struct {
    logic [63:0] mask;
    int          cyc;
    bit          lat;
    bit          has_lit;
    logic [63:0] lit;
  } exp_t;

  exp_t        q[3][$];
  int          n_vec = 0, n_err = 0, cyc = 0;
  bit          lat_chk = 1'b0, lit_on = 1'b0, bp_on = 1'b0;
  logic [63:0] lit_val = '0;
  bit          stall[3];
  logic [63:0] pmask[3], pcnt[3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a bit is set iff its index lies in the interval the mode names.
  function automatic logic [63:0] model(input int w, input int mode, input int a, input int b);
    logic [63:0] m;
    bit in;
    m = '0;
    if (a > w) a = w;
    if (b > w) b = w;
    for (int i = 0; i < w; i++) begin
      case (mode)
        0:       in = (i < a);
        1:       in = (i >= a);
        2:       in = (i >= a) && (i < b);
        default: in = (a <= b) ? ((i >= a) && (i < b)) : ((i >= a) || (i < b));
      endcase
      m[i] = in;
    end
    return m;
  endfunction

  // Scoreboard, sampled on the falling edge where every DUT signal is settled.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        q[k].delete();
        stall[k] = 1'b0;
      end else begin
        string tg;
        exp_t  e;
        tg = $sformatf("w%0d", WV[k]);
        chk({tg, "_in_rdy"}, 64'(irdy[k]), 64'(!(q[k].size() == 2 && !ordy[k])));
        if (stall[k]) begin
          chk({tg, "_hold_vld"},  64'(ovld[k]), 64'd1);
          chk({tg, "_hold_mask"}, omask[k], pmask[k]);
          chk({tg, "_hold_cnt"},  ocnt[k], pcnt[k]);
        end
        if (q[k].size() == 0) begin
          chk({tg, "_idle_vld"}, 64'(ovld[k]), 64'd0);
        end else if (ovld[k] && ordy[k]) begin
          int c;
          e = q[k].pop_front();
          c = $countones(e.mask);
          chk({tg, "_mask"},   omask[k], e.mask);
          chk({tg, "_cnt"},    ocnt[k], 64'(c));
          chk({tg, "_zero"},   64'(ozero[k]), 64'(c == 0));
          chk({tg, "_ones"},   64'(oones[k]), 64'(c == WV[k]));
          chk({tg, "_popcnt"}, ocnt[k], 64'($countones(omask[k])));
          if (e.lat)     chk({tg, "_latency"}, 64'(cyc - e.cyc), 64'd2);
          if (e.has_lit) chk({tg, "_literal"}, omask[k], e.lit);
        end
        if (in_vld && irdy[k]) begin
          int msk;
          msk       = (1 << IWV[k]) - 1;
          e.mask    = model(WV[k], int'(in_mode), int'(ia) & msk, int'(ib) & msk);
          e.cyc     = cyc;
          e.lat     = lat_chk;
          e.has_lit = lit_on && (k == 1);
          e.lit     = lit_val;
          q[k].push_back(e);
        end
        stall[k] = ovld[k] && !ordy[k];
        pmask[k] = omask[k];
        pcnt[k]  = ocnt[k];
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted.
  task automatic send(input int mode, input int a, input int b);
    int n;
    n = 0;
    in_vld = 1'b1; in_mode = 2'(mode); ia = 7'(a); ib = 7'(b);
    forever begin
      @(negedge clk);
      if (irdy[0]) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int left;
    in_vld = 1'b0;
    left = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      left = q[0].size() + q[1].size() + q[2].size();
      if (left == 0) break;
    end
    chk("drain", 64'(left), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_random(input int n);
    bp_on = 1'b1;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int a, b;
          a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 127);
          b = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 127);
          send($urandom_range(0, 3), a, b);
          if ($urandom_range(0, 7) == 0) in_vld = 1'b0;
        end
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          @(posedge clk); #1;
          ordy = 3'($urandom);
        end
      end
    join
    ordy = 3'b111;
    drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held three cycles with a request pending; nothing may emerge.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_out_vld", 64'(ovld), 64'd0);
    end
    rst = 1'b0; in_vld = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_mask", omask[k], 64'd0);
      chk("rst_cnt",  ocnt[k], 64'd0);
      chk("rst_zero", 64'(ozero[k]), 64'd1);
      chk("rst_ones", 64'(oones[k]), 64'd0);
      chk("rst_rdy",  64'(irdy[k]), 64'd1);
    end
    @(posedge clk); #1;

    // Back-to-back LO then HI sweeps, including out-of-range indices.
    lat_chk = 1'b1;
    for (int a = 0; a <= 33; a++) send(0, a, 0);
    for (int a = 0; a <= 33; a++) send(1, a, 0);
    drain();

    // Fixed RANGE/WRAP cases with literal masks for the 12-bit instance.
    lit_on = 1'b1;
    lit_val = 64'h078; send(2, 3, 7);
    lit_val = 64'h000; send(2, 7, 3);
    lit_val = 64'hC03; send(3, 10, 2);
    lit_val = 64'h000; send(3, 5, 5);
    lit_on = 1'b0;
    drain();

    // Backpressure stream, then mid-stream reset.
    lat_chk = 1'b0;
    run_random(8);
    ordy = 3'b000;
    send(0, 5, 0);
    send(1, 7, 0);
    in_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ordy = 3'b111;
    repeat (2) begin @(posedge clk); #1; end
    lat_chk = 1'b1;
    send(2, 4, 20);
    drain();

    // Long randomized run with random consumer stalls.
    lat_chk = 1'b0;
    run_random(2500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
